// File: rtl/fft_bfly_sched.sv
// fft_bfly_sched
//   Address/control sequencer for an in-place radix-2 DIT FFT. For each of
//   LOG2N stages it issues N/2 butterfly read pairs (one per cycle) with the
//   matching twiddle index. It also produces the butterfly valid strobe and
//   the P/Q write-back strobe and addresses, delayed to line up with the
//   RAM read latency and the butterfly pipeline. After each stage it drains
//   for RD_LAT+BF_LAT cycles, so the last write of a stage always lands
//   before the first read of the next stage.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   start                begin a transform (only honoured in IDLE)
//   busy                 high while running or draining
//   done                 one-cycle completion pulse
//   stage                current stage index
//   rd_en                read strobe for both RAM ports
//   rd_addr_a/rd_addr_b  butterfly operand addresses (valid with rd_en)
//   tw_addr              twiddle ROM index k, W = exp(-j*2*pi*k/N)
//   bf_valid             butterfly valid_in (rd_en delayed RD_LAT)
//   wr_en                write strobe for P and Q (rd_en delayed RD_LAT+BF_LAT)
//   wr_addr_p/wr_addr_q  write-back addresses (read addresses, same delay)
module fft_bfly_sched #(
  parameter int N      = 64,
  parameter int LOG2N  = 6,
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [LOG2N-1:0] stage,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic             bf_valid,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_p,
  output logic [LOG2N-1:0] wr_addr_q
);

  localparam int PIPE = RD_LAT + BF_LAT;
  localparam int DW   = (PIPE < 2) ? 1 : $clog2(PIPE);

  localparam logic [LOG2N-1:0] ONE        = LOG2N'(1);
  localparam logic [LOG2N-1:0] J_LAST     = LOG2N'(N/2 - 1);
  localparam logic [LOG2N-1:0] LAST_STAGE = LOG2N'(LOG2N - 1);
  localparam logic [DW-1:0]    DCNT_LAST  = DW'(PIPE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state_reg;
  logic [LOG2N-1:0] j_reg;
  logic [LOG2N-1:0] stage_reg;
  logic [DW-1:0]    dcnt_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             rd_en_reg;
  logic [LOG2N-1:0] a_reg;
  logic [LOG2N-1:0] b_reg;
  logic [LOG2N-2:0] tw_reg;

  // Operand A: groups of 2*span words, A in the lower half of each group.
  function automatic logic [LOG2N-1:0] addr_a(input logic [LOG2N-1:0] s,
                                              input logic [LOG2N-1:0] jj);
    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] pos;
    logic [LOG2N-1:0] grp;
    span = ONE << s;
    pos  = jj & (span - ONE);
    grp  = jj >> s;
    return (grp << (s + ONE)) | pos;
  endfunction

  function automatic logic [LOG2N-1:0] addr_b(input logic [LOG2N-1:0] s,
                                              input logic [LOG2N-1:0] jj);
    return addr_a(s, jj) + (ONE << s);
  endfunction

  // pos < 2^s, so pos << (LOG2N-1-s) always fits in LOG2N-1 bits.
  function automatic logic [LOG2N-2:0] addr_tw(input logic [LOG2N-1:0] s,
                                               input logic [LOG2N-1:0] jj);
    logic [LOG2N-1:0] pos;
    logic [LOG2N-1:0] t;
    pos = jj & ((ONE << s) - ONE);
    t   = pos << (LAST_STAGE - s);
    return t[LOG2N-2:0];
  endfunction

  // Control FSM. Outputs are registered alongside the state so that the
  // address presented with rd_en always belongs to the butterfly in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      j_reg     <= '0;
      stage_reg <= '0;
      dcnt_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      rd_en_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      tw_reg    <= '0;
    end else begin
      done_reg  <= 1'b0;
      rd_en_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      tw_reg    <= '0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg <= S_RUN;
            stage_reg <= '0;
            j_reg     <= '0;
            busy_reg  <= 1'b1;
            rd_en_reg <= 1'b1;
            a_reg     <= addr_a('0, '0);
            b_reg     <= addr_b('0, '0);
            tw_reg    <= addr_tw('0, '0);
          end
        end
        S_RUN: begin
          if (j_reg == J_LAST) begin
            state_reg <= S_DRAIN;
            dcnt_reg  <= '0;
          end else begin
            j_reg     <= j_reg + ONE;
            rd_en_reg <= 1'b1;
            a_reg     <= addr_a(stage_reg, j_reg + ONE);
            b_reg     <= addr_b(stage_reg, j_reg + ONE);
            tw_reg    <= addr_tw(stage_reg, j_reg + ONE);
          end
        end
        S_DRAIN: begin
          if (dcnt_reg == DCNT_LAST) begin
            if (stage_reg == LAST_STAGE) begin
              state_reg <= S_DONE;
              done_reg  <= 1'b1;
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= S_RUN;
              stage_reg <= stage_reg + ONE;
              j_reg     <= '0;
              rd_en_reg <= 1'b1;
              a_reg     <= addr_a(stage_reg + ONE, '0);
              b_reg     <= addr_b(stage_reg + ONE, '0);
              tw_reg    <= addr_tw(stage_reg + ONE, '0);
            end
          end else begin
            dcnt_reg <= dcnt_reg + DW'(1);
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
          stage_reg <= '0;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Delay line matching RAM read latency plus butterfly latency. Reset clears
  // every valid bit so an aborted transform never produces a late write.
  logic [PIPE-1:0]  v_pipe;
  logic [LOG2N-1:0] a_pipe [PIPE];
  logic [LOG2N-1:0] b_pipe [PIPE];

  always_ff @(posedge clk) begin
    if (rst) begin
      v_pipe <= '0;
      for (int i = 0; i < PIPE; i++) begin
        a_pipe[i] <= '0;
        b_pipe[i] <= '0;
      end
    end else begin
      v_pipe    <= {v_pipe[PIPE-2:0], rd_en_reg};
      a_pipe[0] <= a_reg;
      b_pipe[0] <= b_reg;
      for (int i = 1; i < PIPE; i++) begin
        a_pipe[i] <= a_pipe[i-1];
        b_pipe[i] <= b_pipe[i-1];
      end
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign stage     = stage_reg;
  assign rd_en     = rd_en_reg;
  assign rd_addr_a = a_reg;
  assign rd_addr_b = b_reg;
  assign tw_addr   = tw_reg;
  assign bf_valid  = v_pipe[RD_LAT-1];
  assign wr_en     = v_pipe[PIPE-1];
  assign wr_addr_p = a_pipe[PIPE-1];
  assign wr_addr_q = b_pipe[PIPE-1];

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Testbench for fft_bfly_sched: compares every cycle of several transforms
// (plain, start held, random re-pulses, random mid-run resets) with a
// reference schedule computed arithmetically from the cycle number.
module tb_fft_bfly_sched;

  localparam int N      = 64;
  localparam int LOG2N  = 6;
  localparam int RD_LAT = 1;
  localparam int BF_LAT = 3;
  localparam int PIPE   = RD_LAT + BF_LAT;
  localparam int SC     = N/2 + PIPE;        // cycles per stage
  localparam int TOTAL  = LOG2N * SC + 1;    // cycle of the done pulse

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             busy;
  logic             done;
  logic [LOG2N-1:0] stage;
  logic             rd_en;
  logic [LOG2N-1:0] rd_addr_a;
  logic [LOG2N-1:0] rd_addr_b;
  logic [LOG2N-2:0] tw_addr;
  logic             bf_valid;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addr_p;
  logic [LOG2N-1:0] wr_addr_q;

  fft_bfly_sched #(.N(N), .LOG2N(LOG2N), .RD_LAT(RD_LAT), .BF_LAT(BF_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .stage(stage), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .tw_addr(tw_addr), .bf_valid(bf_valid), .wr_en(wr_en),
    .wr_addr_p(wr_addr_p), .wr_addr_q(wr_addr_q)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cur_c = 0;
  int run_id = 0;

  bit hrd [0:TOTAL+16];
  int ha  [0:TOTAL+16];
  int hb  [0:TOTAL+16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s run=%0d cycle=%0d observed=%0d expected=%0d", tag, run_id, cur_c, obs, exp);
    end
  endtask

  // Reference schedule: cycle c after the start edge (c=1 is the first RUN cycle).
  function automatic void model(input int c, output bit rd, output int st,
                                output int a, output int b, output int tw,
                                output bit bz, output bit dn);
    int r, span;
    rd = 0; st = 0; a = 0; b = 0; tw = 0; bz = 0; dn = 0;
    if (c >= 1 && c < TOTAL) begin
      bz = 1;
      st = (c - 1) / SC;
      r  = (c - 1) % SC;
      if (r < N/2) begin
        rd   = 1;
        span = 1 << st;
        a    = (r / span) * 2 * span + (r % span);
        b    = a + span;
        tw   = (r % span) * (N / (2 * span));
      end
    end else if (c == TOTAL) begin
      dn = 1;
    end
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_stage"}, 32'(stage), 0);
    chk({tag, "_rd_en"}, 32'(rd_en), 0);
    chk({tag, "_a"}, 32'(rd_addr_a), 0);
    chk({tag, "_b"}, 32'(rd_addr_b), 0);
    chk({tag, "_tw"}, 32'(tw_addr), 0);
    chk({tag, "_bf_valid"}, 32'(bf_valid), 0);
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_wr_p"}, 32'(wr_addr_p), 0);
    chk({tag, "_wr_q"}, 32'(wr_addr_q), 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cur_c = -1;
      chk("idle_busy", 32'(busy), 0);
      chk("idle_rd_en", 32'(rd_en), 0);
      chk("idle_wr_en", 32'(wr_en), 0);
      chk("idle_done", 32'(done), 0);
    end
  endtask

  // mode 0: single start pulse; 1: start held; 2: random re-pulses while busy.
  // abort_at != 0: rst is sampled at the edge after cycle abort_at.
  task automatic run_xform(input int mode, input int abort_at);
    bit e_rd, e_bz, e_dn, e_bfv, e_wr;
    int e_st, e_a, e_b, e_tw;
    int wr_cnt [LOG2N];
    int last_wr [LOG2N];
    int first_rd [LOG2N];
    int done_cnt, wr_total, s;
    run_id++;
    for (int i = 0; i < LOG2N; i++) begin
      wr_cnt[i] = 0; last_wr[i] = -1; first_rd[i] = -1;
    end
    for (int i = 0; i <= TOTAL + 16; i++) begin
      hrd[i] = 0; ha[i] = 0; hb[i] = 0;
    end
    done_cnt = 0;
    wr_total = 0;
    start = 1'b1;
    for (int c = 1; c <= TOTAL + 4; c++) begin
      @(posedge clk); #1;
      cur_c = c;
      model(c, e_rd, e_st, e_a, e_b, e_tw, e_bz, e_dn);
      hrd[c] = e_rd; ha[c] = e_a; hb[c] = e_b;
      e_bfv = (c > RD_LAT) ? hrd[c-RD_LAT] : 1'b0;
      e_wr  = (c > PIPE) ? hrd[c-PIPE] : 1'b0;
      if (abort_at != 0 && c == abort_at + 1) begin
        check_all_zero("after_rst");
      end else if (abort_at != 0 && c > abort_at + 1) begin
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_rd_en", 32'(rd_en), 0);
        chk("post_rst_wr_en", 32'(wr_en), 0);
        chk("post_rst_bf_valid", 32'(bf_valid), 0);
        chk("post_rst_done", 32'(done), 0);
      end else begin
        chk("busy", 32'(busy), 32'(e_bz));
        chk("done", 32'(done), 32'(e_dn));
        chk("rd_en", 32'(rd_en), 32'(e_rd));
        chk("bf_valid", 32'(bf_valid), 32'(e_bfv));
        chk("wr_en", 32'(wr_en), 32'(e_wr));
        if (e_bz) chk("stage", 32'(stage), 32'(e_st));
        if (e_rd) begin
          chk("rd_addr_a", 32'(rd_addr_a), 32'(e_a));
          chk("rd_addr_b", 32'(rd_addr_b), 32'(e_b));
          chk("tw_addr", 32'(tw_addr), 32'(e_tw));
        end
        if (e_wr) begin
          chk("wr_addr_p", 32'(wr_addr_p), 32'(ha[c-PIPE]));
          chk("wr_addr_q", 32'(wr_addr_q), 32'(hb[c-PIPE]));
        end
        if (abort_at == 0) begin
          if (c == 1) begin
            chk("t1_a0", 32'(rd_addr_a), 0);
            chk("t1_b0", 32'(rd_addr_b), 1);
            chk("t1_tw0", 32'(tw_addr), 0);
          end
          if (c == 2) begin
            chk("t1_a1", 32'(rd_addr_a), 2);
            chk("t1_b1", 32'(rd_addr_b), 3);
          end
          if (c == 78) begin
            chk("t2_s2j5_a", 32'(rd_addr_a), 9);
            chk("t2_s2j5_b", 32'(rd_addr_b), 13);
            chk("t2_s2j5_tw", 32'(tw_addr), 8);
          end
          if (c == 212) begin
            chk("t2_s5j31_a", 32'(rd_addr_a), 31);
            chk("t2_s5j31_b", 32'(rd_addr_b), 63);
            chk("t2_s5j31_tw", 32'(tw_addr), 31);
          end
        end
      end
      // Bookkeeping from observed outputs for per-stage and hazard checks.
      if (done) done_cnt++;
      if (wr_en) begin
        wr_total++;
        s = (c - 1 - PIPE) / SC;
        if (c > PIPE && s < LOG2N) begin
          wr_cnt[s]++;
          last_wr[s] = c;
        end
      end
      if (rd_en && int'(stage) < LOG2N && first_rd[stage] < 0) first_rd[stage] = c;
      // Drive inputs for the next edge.
      rst = (abort_at != 0 && c == abort_at);
      if (c >= TOTAL || mode == 0) start = 1'b0;
      else if (mode == 1) start = 1'b1;
      else start = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    rst = 1'b0;
    if (abort_at == 0) begin
      for (int i = 0; i < LOG2N; i++) chk("wr_per_stage", 32'(wr_cnt[i]), N/2);
      chk("wr_total", 32'(wr_total), LOG2N * N/2);
      for (int i = 0; i < LOG2N - 1; i++)
        chk("hazard_order", 32'(last_wr[i] >= 0 && last_wr[i] < first_rd[i+1]), 1);
      chk("done_pulses", 32'(done_cnt), 1);
    end else begin
      chk("abort_no_done", 32'(done_cnt), 0);
    end
    $display("[TB] run %0d mode=%0d abort_at=%0d writes=%0d done_pulses=%0d",
             run_id, mode, abort_at, wr_total, done_cnt);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cur_c = 0;
    check_all_zero("reset");
    rst = 1'b0;
    idle($urandom_range(1, 5));
    run_xform(0, 0);
    idle($urandom_range(1, 5));
    run_xform(0, 50);
    idle(2);
    run_xform(0, 0);
    run_xform(1, 0);
    idle($urandom_range(1, 5));
    run_xform(2, 0);
    idle($urandom_range(1, 5));
    run_xform(0, $urandom_range(10, 210));
    idle(1);
    run_xform(2, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
